id_decode_stage: RTL

//  Registered instruction-decode stage for the MIPS pipeline core; supersedes purely combinational op decode.

---
 rtl/id_decode_stage_if.sv | 25 ++
 rtl/id_decode_stage.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/id_decode_stage_if.sv
// Upstream (IF -> ID) and downstream (ID -> ID/EX) valid/ready bundle of the decode stage.
// The master side drives instructions in and consumes decoded entries; the slave side is the stage itself.
interface id_decode_stage_if #(
  parameter int PC_W = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     in_instr;
  logic [PC_W-1:0] in_pc;
  logic            out_valid;
  logic            out_ready;
  logic [31:0]     out_instr;
  logic [PC_W-1:0] out_pc;
  logic [21:0]     out_ctrl;

  modport master (
    output in_valid, in_instr, in_pc, out_ready,
    input  in_ready, out_valid, out_instr, out_pc, out_ctrl
  );

  modport slave (
    input  in_valid, in_instr, in_pc, out_ready,
    output in_ready, out_valid, out_instr, out_pc, out_ctrl
  );
endinterface

// File: rtl/id_decode_stage.sv
// Registered MIPS instruction-decode stage: combinational op/rt/funct decode captured into a
// two-entry elastic buffer (main + skid) so in_ready is a register independent of out_ready.
module id_decode_stage #(
  parameter int PC_W   = 32,
  parameter bit EXT_LS = 1'b1,
  parameter bit EXT_JR = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  id_decode_stage_if.slave  bus
);

  typedef enum logic [1:0] {ST_EMPTY, ST_ONE, ST_FULL} state_t;

  logic [5:0]  w_op;
  logic [4:0]  w_rt;
  logic [5:0]  w_funct;
  logic        w_regwrite, w_regdst, w_alusrc, w_branch, w_memwrite, w_memtoreg;
  logic        w_jump, w_jr, w_hassign, w_islui, w_link, w_illegal;
  logic [2:0]  w_aluop, w_mem_op, w_branch_op;
  logic [21:0] w_ctrl;
  logic        w_accept;
  logic        w_pop;

  state_t          r_state;
  logic            r_in_ready;
  logic            r_out_valid;
  logic [31:0]     r_main_instr;
  logic [PC_W-1:0] r_main_pc;
  logic [21:0]     r_main_ctrl;
  logic [31:0]     r_skid_instr;
  logic [PC_W-1:0] r_skid_pc;
  logic [21:0]     r_skid_ctrl;

  assign w_op    = bus.in_instr[31:26];
  assign w_rt    = bus.in_instr[20:16];
  assign w_funct = bus.in_instr[5:0];

  always_comb begin
    w_regwrite  = 1'b0;
    w_regdst    = 1'b0;
    w_alusrc    = 1'b0;
    w_branch    = 1'b0;
    w_memwrite  = 1'b0;
    w_memtoreg  = 1'b0;
    w_jump      = 1'b0;
    w_jr        = 1'b0;
    w_aluop     = 3'b000;
    w_hassign   = 1'b0;
    w_islui     = 1'b0;
    w_mem_op    = 3'b000;
    w_branch_op = 3'b000;
    w_link      = 1'b0;
    w_illegal   = 1'b0;
    case (w_op)
      6'h00: begin
        if (EXT_JR && w_funct == 6'b001000) begin
          w_jump = 1'b1;
          w_jr   = 1'b1;
        end else if (EXT_JR && w_funct == 6'b001001) begin
          w_regwrite = 1'b1;
          w_regdst   = 1'b1;
          w_jump     = 1'b1;
          w_jr       = 1'b1;
          w_link     = 1'b1;
        end else begin
          w_regwrite = 1'b1;
          w_regdst   = 1'b1;
          w_aluop    = 3'b010;
        end
      end
      6'h01: begin
        case (w_rt)
          5'd0, 5'd1, 5'd16, 5'd17: begin
            w_branch    = 1'b1;
            w_aluop     = 3'b001;
            w_branch_op = {2'b10, w_rt[0]};
            w_regwrite  = w_rt[4];
            w_link      = w_rt[4];
          end
          default: w_illegal = 1'b1;
        endcase
      end
      6'h02: w_jump = 1'b1;
      6'h03: begin
        w_regwrite = 1'b1;
        w_jump     = 1'b1;
        w_link     = 1'b1;
      end
      6'h04, 6'h05, 6'h06, 6'h07: begin
        w_branch = 1'b1;
        w_aluop  = 3'b001;
        case (w_op[1:0])
          2'b00:   w_branch_op = 3'b000;
          2'b01:   w_branch_op = 3'b001;
          2'b10:   w_branch_op = 3'b011;
          default: w_branch_op = 3'b010;
        endcase
      end
      6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E, 6'h0F: begin
        w_regwrite = 1'b1;
        w_alusrc   = 1'b1;
        w_hassign  = (w_op == 6'h0A);
        w_islui    = (w_op == 6'h0F);
        case (w_op[2:0])
          3'd2, 3'd3: w_aluop = 3'b011;
          3'd4:       w_aluop = 3'b100;
          3'd5:       w_aluop = 3'b101;
          3'd6:       w_aluop = 3'b110;
          default:    w_aluop = 3'b000;
        endcase
      end
      // Sub-word loads/stores are only legal when the LS extension is built in; LW/SW always are.
      6'h20, 6'h21, 6'h23, 6'h24, 6'h25: begin
        if (EXT_LS || w_op == 6'h23) begin
          w_regwrite = 1'b1;
          w_alusrc   = 1'b1;
          w_memtoreg = 1'b1;
          case (w_op[2:0])
            3'd0:    w_mem_op = 3'b110;
            3'd1:    w_mem_op = 3'b100;
            3'd4:    w_mem_op = 3'b111;
            3'd5:    w_mem_op = 3'b101;
            default: w_mem_op = 3'b000;
          endcase
        end else begin
          w_illegal = 1'b1;
        end
      end
      6'h28, 6'h29, 6'h2B: begin
        if (EXT_LS || w_op == 6'h2B) begin
          w_alusrc   = 1'b1;
          w_memwrite = 1'b1;
          case (w_op[1:0])
            2'd0:    w_mem_op = 3'b010;
            2'd1:    w_mem_op = 3'b001;
            default: w_mem_op = 3'b000;
          endcase
        end else begin
          w_illegal = 1'b1;
        end
      end
      default: w_illegal = 1'b1;
    endcase
  end

  // Listed fields total 21 bits; the MSB of the 22-bit bundle is reserved and always 0.
  assign w_ctrl = {1'b0, w_regwrite, w_regdst, w_alusrc, w_branch, w_memwrite, w_memtoreg,
                   w_jump, w_jr, w_aluop, w_hassign, w_islui, w_mem_op, w_branch_op,
                   w_link, w_illegal};

  assign w_accept = bus.in_valid & r_in_ready;
  assign w_pop    = r_out_valid & bus.out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_EMPTY;
      r_in_ready   <= 1'b1;
      r_out_valid  <= 1'b0;
      r_main_instr <= '0;
      r_main_pc    <= '0;
      r_main_ctrl  <= '0;
      r_skid_instr <= '0;
      r_skid_pc    <= '0;
      r_skid_ctrl  <= '0;
    end else if (flush) begin
      r_state      <= ST_EMPTY;
      r_in_ready   <= 1'b1;
      r_out_valid  <= 1'b0;
      r_main_instr <= '0;
      r_main_pc    <= '0;
      r_main_ctrl  <= '0;
      r_skid_instr <= '0;
      r_skid_pc    <= '0;
      r_skid_ctrl  <= '0;
    end else begin
      case (r_state)
        ST_EMPTY: begin
          if (w_accept) begin
            r_main_instr <= bus.in_instr;
            r_main_pc    <= bus.in_pc;
            r_main_ctrl  <= w_ctrl;
            r_out_valid  <= 1'b1;
            r_state      <= ST_ONE;
          end
        end
        ST_ONE: begin
          if (w_pop && w_accept) begin
            r_main_instr <= bus.in_instr;
            r_main_pc    <= bus.in_pc;
            r_main_ctrl  <= w_ctrl;
          end else if (w_pop) begin
            r_out_valid <= 1'b0;
            r_state     <= ST_EMPTY;
          end else if (w_accept) begin
            r_skid_instr <= bus.in_instr;
            r_skid_pc    <= bus.in_pc;
            r_skid_ctrl  <= w_ctrl;
            r_in_ready   <= 1'b0;
            r_state      <= ST_FULL;
          end
        end
        ST_FULL: begin
          // in_ready is low here, so only the skid-to-main shift can happen.
          if (w_pop) begin
            r_main_instr <= r_skid_instr;
            r_main_pc    <= r_skid_pc;
            r_main_ctrl  <= r_skid_ctrl;
            r_in_ready   <= 1'b1;
            r_state      <= ST_ONE;
          end
        end
        default: begin
          r_state     <= ST_EMPTY;
          r_in_ready  <= 1'b1;
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready  = r_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.out_instr = r_main_instr;
  assign bus.out_pc    = r_main_pc;
  assign bus.out_ctrl  = r_main_ctrl;

endmodule
